// File: rtl/gpio_in_capture.sv
// gpio_in_capture: synchronizes and debounces GPIO pad inputs, latches
// per-bit edge events (write-1-to-clear) and raises a registered interrupt.
module gpio_in_capture #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic             clr_strobe,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] event_out,
  output logic             irq
);

  localparam int              CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] ev_set;
  logic [WIDTH-1:0] ev_clr;

  // Two-flop synchronizer on the raw pads; nothing downstream sees pin_in.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking assignments here would collapse s1/s2 into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

  // A bit commits when it has disagreed with level_out for DB_CYCLES edges.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = (s2[i] != level_out[i]) && (cnt[i] == CNT_LAST);
    end
    ev_set = (update & s2 & rise_en) | (update & ~s2 & fall_en);
    ev_clr = clr_strobe ? clr_mask : '0;
  end

  // Per-bit debounce counters: run while s2 disagrees, clear on agreement or commit.
  // NOTE: the counter array is ordinary flops, not a RAM, so it is reset
  // with everything else; an unreset counter could commit a stale level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == level_out[i] || update[i]) cnt[i] <= '0;
        else                                    cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  // Debounced level; a committing bit takes the synchronized value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_out <= '0;
    else     level_out <= (level_out & ~update) | (s2 & update);
  end

  // Sticky events: a new set on the same edge beats a software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) event_out <= '0;
    else     event_out <= (event_out & ~ev_clr) | ev_set;
  end

  // Interrupt is registered from the current event and mask values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(event_out & irq_mask);
  end

endmodule

// File: tb/tb_gpio_in_capture.sv
// Testbench for gpio_in_capture: directed scenarios plus randomized traffic
// compared against a sliding-window reference model.
module tb_gpio_in_capture;

  localparam int W  = 16;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pin_in, rise_en, fall_en, irq_mask, clr_mask;
  logic         clr_strobe;
  logic [W-1:0] level_out, event_out;
  logic         irq;

  int checks   = 0;
  int failures = 0;

  gpio_in_capture #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .rise_en(rise_en),
    .fall_en(fall_en), .irq_mask(irq_mask), .clr_strobe(clr_strobe),
    .clr_mask(clr_mask), .level_out(level_out), .event_out(event_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: hist[0] is the pin value sampled at the latest edge.
  // A bit's level flips at an edge when the DB samples that have made it
  // through the synchronizer all disagree with the current level.
  logic [W-1:0] hist [0:DB];
  logic [W-1:0] m_level, m_event;
  logic         m_irq;

  function automatic logic [W-1:0] model_next_level();
    logic [W-1:0] nl;
    nl = m_level;
    for (int i = 0; i < W; i++) begin
      bit all_diff = 1'b1;
      for (int j = 1; j <= DB; j++)
        if (hist[j][i] == m_level[i]) all_diff = 1'b0;
      if (all_diff) nl[i] = ~m_level[i];
    end
    return nl;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level <= '0;
      m_event <= '0;
      m_irq   <= 1'b0;
      for (int j = 0; j <= DB; j++) hist[j] <= '0;
    end else begin
      m_irq   <= |(m_event & irq_mask);
      m_level <= model_next_level();
      m_event <= (m_event & ~(clr_strobe ? clr_mask : '0))
               | (~m_level & model_next_level() & rise_en)
               | (m_level & ~model_next_level() & fall_en);
      hist[0] <= pin_in;
      for (int j = 1; j <= DB; j++) hist[j] <= hist[j-1];
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    pin_in = '0; rise_en = '0; fall_en = '0; irq_mask = '0;
    clr_strobe = 1'b0; clr_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    if ({level_out, event_out, irq} !== {(2*W+1){1'b0}}) begin
      $display("FAIL reset_state: got lvl=%h ev=%h irq=%b required all zero", level_out, event_out, irq);
      failures++;
    end
    checks++;
    apply_reset();
  endtask

  // Rising edge on bit 0 with irq enabled: level/event at edge 6, irq at edge 7.
  task automatic test_rise_irq();
    apply_reset();
    rise_en = 16'h0001; irq_mask = 16'h0001;
    @(negedge clk) pin_in = 16'h0001;
    for (int e = 1; e <= 8; e++) begin
      logic [W-1:0] exp_v;
      logic         exp_i;
      @(posedge clk); #1;
      exp_v = (e >= 6) ? 16'h0001 : 16'h0000;
      exp_i = (e >= 7);
      if (level_out !== exp_v || event_out !== exp_v || irq !== exp_i) begin
        $display("FAIL rise_irq edge %0d: got lvl=%h ev=%h irq=%b required lvl=%h ev=%h irq=%b",
                 e, level_out, event_out, irq, exp_v, exp_v, exp_i);
        failures++;
      end
      checks++;
    end
  endtask

  // Three-cycle pulse on bit 3 is shorter than the debounce window.
  task automatic test_glitch();
    apply_reset();
    rise_en = '1; fall_en = '1;
    @(negedge clk) pin_in = 16'h0008;
    repeat (3) @(negedge clk);
    pin_in = 16'h0000;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (level_out !== 16'h0000 || event_out !== 16'h0000) begin
        $display("FAIL glitch cycle %0d: got lvl=%h ev=%h required 0000/0000", e, level_out, event_out);
        failures++;
      end
      checks++;
    end
  endtask

  // Write-1-to-clear, and clr_mask ignored without the strobe.
  task automatic test_clear();
    apply_reset();
    rise_en = 16'h0005;
    @(negedge clk) pin_in = 16'h0005;
    repeat (6) @(posedge clk);
    #1;
    if (event_out !== 16'h0005) begin
      $display("FAIL clear_setup: got ev=%h required 0005", event_out); failures++;
    end
    checks++;
    @(negedge clk) begin clr_strobe = 1'b1; clr_mask = 16'h0004; end
    @(posedge clk); #1;
    if (event_out !== 16'h0001) begin
      $display("FAIL clear_bit2: got ev=%h required 0001", event_out); failures++;
    end
    checks++;
    @(negedge clk) begin clr_strobe = 1'b0; clr_mask = 16'hFFFF; end
    repeat (3) @(posedge clk);
    #1;
    if (event_out !== 16'h0001) begin
      $display("FAIL clear_no_strobe: got ev=%h required 0001", event_out); failures++;
    end
    checks++;
  endtask

  // Event set and clear for bit 2 on the same edge: set wins.
  task automatic test_set_wins();
    apply_reset();
    rise_en = 16'h0004;
    @(negedge clk) pin_in = 16'h0004;
    repeat (5) @(posedge clk);
    @(negedge clk) begin clr_strobe = 1'b1; clr_mask = 16'h0004; end
    @(posedge clk); #1;
    if (level_out !== 16'h0004 || event_out !== 16'h0004) begin
      $display("FAIL set_wins: got lvl=%h ev=%h required 0004/0004", level_out, event_out); failures++;
    end
    checks++;
    @(negedge clk) clr_strobe = 1'b1;
    @(posedge clk); #1;
    if (event_out !== 16'h0000) begin
      $display("FAIL set_wins_later_clear: got ev=%h required 0000", event_out); failures++;
    end
    checks++;
    @(negedge clk) clr_strobe = 1'b0;
  endtask

  // Falling edge on bit 15 with irq masked off.
  task automatic test_fall();
    apply_reset();
    fall_en = 16'h8000; irq_mask = 16'h0000;
    @(negedge clk) pin_in = 16'h8000;
    repeat (8) @(posedge clk);
    #1;
    if (level_out !== 16'h8000 || event_out !== 16'h0000) begin
      $display("FAIL fall_setup: got lvl=%h ev=%h required 8000/0000", level_out, event_out); failures++;
    end
    checks++;
    @(negedge clk) pin_in = 16'h0000;
    for (int e = 1; e <= 8; e++) begin
      logic [W-1:0] exp_e;
      @(posedge clk); #1;
      exp_e = (e >= 6) ? 16'h8000 : 16'h0000;
      if (event_out !== exp_e || irq !== 1'b0) begin
        $display("FAIL fall edge %0d: got ev=%h irq=%b required ev=%h irq=0", e, event_out, irq, exp_e);
        failures++;
      end
      checks++;
    end
  endtask

  // Asynchronous reset mid-debounce, then recovery with pins held high.
  task automatic test_reset_mid();
    apply_reset();
    rise_en = '1; irq_mask = '1;
    @(negedge clk) pin_in = 16'hFFFF;
    repeat (8) @(posedge clk);
    #1;
    if (level_out !== 16'hFFFF || event_out !== 16'hFFFF || irq !== 1'b1) begin
      $display("FAIL reset_mid_setup: got lvl=%h ev=%h irq=%b required FFFF/FFFF/1", level_out, event_out, irq);
      failures++;
    end
    checks++;
    @(negedge clk) pin_in = 16'h0000;
    repeat (3) @(posedge clk);
    #2 pin_in = 16'hFFFF; rst = 1'b1;
    #1;
    if (level_out !== 16'h0000 || event_out !== 16'h0000 || irq !== 1'b0) begin
      $display("FAIL reset_mid_async: got lvl=%h ev=%h irq=%b required all zero", level_out, event_out, irq);
      failures++;
    end
    checks++;
    @(negedge clk) rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      logic [W-1:0] exp_v;
      @(posedge clk); #1;
      exp_v = (e >= 6) ? 16'hFFFF : 16'h0000;
      if (level_out !== exp_v || event_out !== exp_v) begin
        $display("FAIL reset_mid_recover edge %0d: got lvl=%h ev=%h required %h", e, level_out, event_out, exp_v);
        failures++;
      end
      checks++;
    end
  endtask

  // Randomized pin activity, enables and clears against the reference model.
  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 7) == 0) pin_in[i] = ~pin_in[i];
      if (c % 64 == 0) begin
        rise_en = W'($urandom); fall_en = W'($urandom); irq_mask = W'($urandom);
      end
      clr_strobe = ($urandom_range(0, 5) == 0);
      clr_mask   = W'($urandom);
      @(posedge clk); #1;
      if (level_out !== m_level || event_out !== m_event || irq !== m_irq) begin
        $display("FAIL random cycle %0d: got lvl=%h ev=%h irq=%b required lvl=%h ev=%h irq=%b",
                 c, level_out, event_out, irq, m_level, m_event, m_irq);
        failures++;
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_glitch();
    test_clear();
    test_set_wins();
    test_fall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_in_capture.md
GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of input pins captured.
REQ-002 SHALL have parameter DB_CYCLES, default 4: debounce length in clk cycles; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port pin_in, input, WIDTH: raw asynchronous pad inputs from the gpio_port Input buses.
REQ-006 SHALL have port rise_en, input, WIDTH: per-bit enable for rising-edge events.
REQ-007 SHALL have port fall_en, input, WIDTH: per-bit enable for falling-edge events.
REQ-008 SHALL have port irq_mask, input, WIDTH: per-bit interrupt enable.
REQ-009 SHALL have port clr_strobe, input, 1: one-cycle register-write pulse from the GPMC register file.
REQ-010 SHALL have port clr_mask, input, WIDTH: write-1-to-clear event mask, qualified by clr_strobe.
REQ-011 SHALL have port level_out, output, WIDTH: debounced pin level, read back via the register file.
REQ-012 SHALL have port event_out, output, WIDTH: sticky edge-event flags.
REQ-013 SHALL have port irq, output, 1: registered interrupt request.

Function
REQ-014 SHALL pass each pin_in bit through a two-flop synchronizer (s1, s2) before any other use.
REQ-015 SHALL keep one debounce counter per bit, width ceil(log2(DB_CYCLES+1)), counting only while s2 differs from level_out for that bit.
REQ-016 SHALL clear a bit's counter on any cycle where its s2 equals level_out.
REQ-017 SHALL, on the edge where s2 differs from level_out and the counter equals DB_CYCLES-1, load level_out with s2 and clear the counter.
REQ-018 SHALL therefore update level_out on the (DB_CYCLES+2)th rising clk edge after a clean pin transition, counting the first sampling edge as 1.
REQ-019 SHALL reject any synchronized glitch shorter than DB_CYCLES cycles, with no level_out change and no event.
REQ-020 SHALL set event_out[i] on the same edge level_out[i] goes 0->1 when rise_en[i]=1, or goes 1->0 when fall_en[i]=1.
REQ-021 SHALL hold event_out bits set until cleared by clr_strobe=1 with the matching clr_mask bit =1; clr_mask is ignored when clr_strobe=0.
REQ-022 SHALL let set win over clear when both occur for the same bit on the same edge.
REQ-023 SHALL leave existing event_out bits unchanged when rise_en or fall_en is deasserted.
REQ-024 SHALL register irq as the OR-reduction of (event_out & irq_mask), one cycle behind event_out and irq_mask.
REQ-025 SHALL process all WIDTH bits independently; simultaneous transitions on several bits produce simultaneous updates.

Reset
REQ-026 SHALL, while rst=1, force s1, s2, counters, level_out, event_out and irq to 0 immediately, independent of clk.
REQ-027 SHALL, on rst deassertion mid-debounce, restart from level_out=0; a pin held high gives level_out=1 DB_CYCLES+2 edges after release, with an event if rise_en is set.
REQ-028 SHALL generate no event for the reset-to-0 transition of level_out.

Verification
REQ-029 DB_CYCLES=4, rise_en=0x0001, irq_mask=0x0001; pin_in[0] 0->1 held -> level_out[0]=1 and event_out=0x0001 at edge 6, irq=1 at edge 7.
REQ-030 pin_in[3] high pulse of 3 cycles, DB_CYCLES=4 -> level_out and event_out stay 0x0000 throughout.
REQ-031 event_out=0x0005; clr_strobe=1, clr_mask=0x0004 -> event_out=0x0001 next edge; clr_mask=0xFFFF with clr_strobe=0 -> no change.
REQ-032 Rising event on bit 2 qualifies on the same edge as clr_strobe=1, clr_mask=0x0004 -> event_out[2] stays 1.
REQ-033 fall_en=0x8000, pin_in[15] 1->0 after a settled high -> event_out=0x8000 at edge 6; irq_mask=0 -> irq stays 0.
REQ-034 rst asserted mid-debounce with pin_in=0xFFFF -> all outputs 0 immediately; after release, level_out=0xFFFF at edge 6.
